// File: rtl/sar_pkg.sv
// sar_pkg: shared constants, accumulator width helper and FSM states for the SAR result averager.
package sar_pkg;
    localparam int DW_DEFAULT = 12;
    typedef enum logic [1:0] {IDLE, ACCUM, PUSH} state_t;
    function automatic int acc_w(input int dw, input int log2n);
        return dw + log2n;
    endfunction
endpackage

// File: rtl/sar_avg_fifo.sv
// sar_avg_fifo: synchronous FIFO with valid/ready pop, sticky overflow on dropped pushes and occupancy.
module sar_avg_fifo #(
    parameter int W = 12,
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     ready,
    output logic [W-1:0]             dout,
    output logic                     valid,
    output logic                     ovf,
    output logic [$clog2(DEPTH):0]   fill
);
    localparam int PW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [PW-1:0] wr, rd;
    logic [PW:0] cnt;
    logic full, pop, wen;
    assign valid = cnt != '0;
    assign full = cnt == (PW+1)'(DEPTH);
    assign pop = valid && ready;
    // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign wen = push && (!full || pop);
    assign dout = valid ? mem[rd] : '0;
    assign fill = cnt;
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr <= '0;
            rd <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else begin
            if (wen) wr <= wr + 1'b1;
            if (pop) rd <= rd + 1'b1;
            cnt <= cnt + (PW+1)'(wen) - (PW+1)'(pop);
            if (push && !wen) ovf <= 1'b1;
        end
    end
    always_ff @(posedge CLK) if (wen) mem[wr] <= din;
endmodule

// File: rtl/sar_result_averager.sv
// sar_result_averager: synchronises SAR EOC, averages 2**LOG2_N results and queues them for a valid/ready consumer.
// Define SAR_AVG_MINMAX_EN to also track and queue each window's min and max sample.
module sar_result_averager
    import sar_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int LOG2_N = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          ENABLE,
    input  logic                          EOC,
    input  logic [0:DW-1]                 DIN,
    output logic [0:DW-1]                 AVG_DATA,
    output logic                          AVG_VALID,
    input  logic                          AVG_READY,
    output logic                          OVF,
`ifdef SAR_AVG_MINMAX_EN
    output logic [0:DW-1]                 AVG_MIN,
    output logic [0:DW-1]                 AVG_MAX,
`endif
    output logic [$clog2(FIFO_DEPTH):0]   FILL
);
    localparam int AW = acc_w(DW, LOG2_N);
    localparam int CW = LOG2_N + 1;
    localparam int HALF = (1 << LOG2_N) >> 1;
`ifdef SAR_AVG_MINMAX_EN
    localparam int EW = 3 * DW;
`else
    localparam int EW = DW;
`endif
    state_t state, state_n;
    logic [2:0] eoc_s;
    logic cap, push, idle;
    logic [AW-1:0] acc, acc_b, acc_n;
    logic [CW-1:0] cnt, cnt_b, cnt_n;
    logic [AW:0] rnd;
    logic [0:DW-1] res;
    logic [EW-1:0] entry, head;
    // eoc_s[1:0] is the synchroniser, eoc_s[2] the previous level for edge detect
    assign cap = eoc_s[1] & ~eoc_s[2];
    assign push = state == PUSH;
    assign idle = state == IDLE;
    assign acc_b = push ? '0 : acc;
    assign cnt_b = push ? '0 : cnt;
    assign rnd = ({1'b0, acc} + (AW+1)'(HALF)) >> LOG2_N;
    assign res = (rnd > (AW+1)'(2**DW - 1)) ? '1 : rnd[DW-1:0];
    always_comb begin
        acc_n = (!ENABLE || idle) ? '0 : acc_b + (cap ? AW'(DIN) : '0);
        cnt_n = (!ENABLE || idle) ? '0 : cnt_b + CW'(cap);
        state_n = !ENABLE ? IDLE : (!idle && cap && cnt_b == CW'((1 << LOG2_N) - 1)) ? PUSH : ACCUM;
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            eoc_s <= '0;
            state <= IDLE;
            acc <= '0;
            cnt <= '0;
        end else begin
            eoc_s <= {eoc_s[1:0], EOC};
            state <= state_n;
            acc <= acc_n;
            cnt <= cnt_n;
        end
    end
`ifdef SAR_AVG_MINMAX_EN
    logic [0:DW-1] mn, mx, mn_b, mx_b, mn_n, mx_n;
    assign mn_b = push ? '1 : mn;
    assign mx_b = push ? '0 : mx;
    always_comb begin
        mn_n = (!ENABLE || idle) ? '1 : (cap && DIN < mn_b) ? DIN : mn_b;
        mx_n = (!ENABLE || idle) ? '0 : (cap && DIN > mx_b) ? DIN : mx_b;
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            mn <= '1;
            mx <= '0;
        end else begin
            mn <= mn_n;
            mx <= mx_n;
        end
    end
    assign entry = {res, mn, mx};
    assign {AVG_DATA, AVG_MIN, AVG_MAX} = head;
`else
    assign entry = res;
    assign AVG_DATA = head;
`endif
    sar_avg_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (push),
        .din   (entry),
        .ready (AVG_READY),
        .dout  (head),
        .valid (AVG_VALID),
        .ovf   (OVF),
        .fill  (FILL)
    );
endmodule
